// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (same constants as the ALU decoder)
// and the execution-unit FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NU1 = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_NU2 = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/multicycle_alu_shift_add_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// The load edge already performs the first iteration, so WIDTH edges in total.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] count;

  assign busy     = (count != '0);
  assign last     = (count == CNT_W'(1));
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      // Bit 0 of b is consumed here; WIDTH-1 iterations remain.
      mcand  <= a << 1;
      mplier <= b >> 1;
      acc    <= b[0] ? a : '0;
      count  <= CNT_INIT;
    end else if (busy) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execution unit: single-cycle AND/OR/ADD/SUB/SLT and a WIDTH-cycle iterative
// MUL, with a start/ready/done handshake so control can stall on MUL.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);

  state_t state;
  state_t state_next;

  logic                    accept;
  logic                    mul_load;
  logic                    mul_busy;
  logic                    mul_last;
  logic [WIDTH-1:0]        mul_product;
  logic signed [WIDTH-1:0] src_a_s;
  logic signed [WIDTH-1:0] src_b_s;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ill;
  logic [WIDTH-1:0]        result_next;
  logic                    zero_next;
  logic                    done_next;
  logic                    illegal_next;

  assign ready    = (state == ST_IDLE);
  assign accept   = start && ready;
  assign mul_load = accept && (ALUControl == ALU_MUL);
  assign src_a_s  = SrcA;
  assign src_b_s  = SrcB;

  shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .a       (SrcA),
    .b       (SrcB),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUControl)
      ALU_AND: alu_res = SrcA & SrcB;
      ALU_OR:  alu_res = SrcA | SrcB;
      ALU_ADD: alu_res = SrcA + SrcB;
      ALU_SUB: alu_res = SrcA - SrcB;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
      ALU_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state;
    result_next  = ALUResult;
    zero_next    = Zero;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (ALUControl == ALU_MUL) begin
            state_next = ST_MUL;
          end else begin
            result_next  = alu_res;
            zero_next    = (alu_res == '0);
            done_next    = 1'b1;
            illegal_next = alu_ill;
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          result_next = mul_product;
          zero_next   = (mul_product == '0);
          done_next   = 1'b1;
          state_next  = ST_IDLE;
        end else if (!mul_busy) begin
          // Engine idle without a completion: never expected, recover to IDLE.
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      illegal   <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      done      <= done_next;
      illegal   <= illegal_next;
      ALUResult <= result_next;
      Zero      <= zero_next;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized scoreboard bench for multicycle_alu: driver pushes expected
// responses, an independent monitor pops and compares on every done pulse.
module tb_multicycle_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    ALUControl;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic          ready;
  logic          done;
  logic [W-1:0]  ALUResult;
  logic          Zero;
  logic          illegal;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ready      (ready),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           lat;
    int           acc_cyc;
    logic [2:0]   op;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned p;
    e.res = '0;
    e.ill = 1'b0;
    e.lat = 1;
    e.op  = op;
    e.acc_cyc = 0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: e.res = W'(longint'(a) + longint'(b));
      3'b100: e.res = W'(longint'(a) - longint'(b));
      3'b101: begin
        p = longint'(a) * longint'(b);
        e.res = W'(p);
        e.lat = W;
      end
      3'b110: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int waits;
    @(negedge clk);
    start = 1'b1;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    waits = 0;
    while (!ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: ready stuck at %b, expected 1", ready);
      start = 1'b0;
      return;
    end
    e = model(op, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Deassert start and scramble the operand/opcode inputs.
  task automatic drop();
    @(negedge clk);
    start = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
    ALUControl = 3'($urandom);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("result_op%b", e.op), 64'(ALUResult), 64'(e.res));
        chk($sformatf("zero_op%b", e.op), 64'(Zero), 64'(e.res == '0));
        chk($sformatf("illegal_op%b", e.op), 64'(illegal), 64'(e.ill));
        chk($sformatf("latency_op%b", e.op), 64'(cyc - e.acc_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    int low;
    int dones;
    int gap;
    rst_n = 1'b0;
    start = 1'b0;
    ALUControl = 3'b000;
    SrcA = '0;
    SrcB = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_result", 64'(ALUResult), 64'(0));
    chk("rst_zero", 64'(Zero), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'(1));

    // Back-to-back single-cycle ops
    issue(3'b010, 32'd5, 32'd7);
    issue(3'b100, 32'd3, 32'd3);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(3'b110, 32'hFFFF_FFFF, 32'd1);
    drop();
    repeat (3) @(negedge clk);

    // MUL with junk inputs after accept
    issue(3'b101, 32'h0001_0003, 32'h0000_0005);
    drop();
    low = 0;
    while (!ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("mul_ready_low_cycles", 64'(low), 64'(W - 1));
    repeat (2) @(negedge clk);

    // MUL wrap cases
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'b101, 32'h8000_0000, 32'd2);
    // start held with ADD during MUL: accepted only in the done cycle
    issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF1);
    issue(3'b010, 32'h1111_1111, 32'h2222_2222);
    drop();
    repeat (3) @(negedge clk);

    // Undefined codes and ADD wrap into sign bit
    issue(3'b011, $urandom, $urandom);
    issue(3'b111, $urandom, $urandom);
    issue(3'b010, 32'h7FFF_FFFF, 32'd1);
    drop();
    repeat (3) @(negedge clk);

    // Reset mid-MUL aborts with no done
    issue(3'b101, 32'h0000_0007, 32'h0000_0009);
    drop();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midmul_rst_done", 64'(done), 64'(0));
    chk("midmul_rst_ready", 64'(ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    chk("midmul_rst_result", 64'(ALUResult), 64'(0));
    chk("midmul_rst_zero", 64'(Zero), 64'(1));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midmul_no_done", 64'(dones), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        drop();
        repeat (gap - 1) @(negedge clk);
      end
    end
    drop();

    low = 0;
    while (sb.size() != 0 && low < 200) begin
      @(negedge clk);
      low++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
